// File: rtl/fec32_dec.sv
// Receive-side FEC 2/3 decoder for the shortened (15,10) Hamming code, g(D)=D^5+D^4+D^2+1.
// Serial syndrome accumulation, 1-cycle single-error correction, saturating error counters.
module fec32_dec #(
  parameter int CNT_W = 8
) (
  input  logic             clk_6M,
  input  logic             rst,
  input  logic             loadini_p,
  input  logic             datvalid_p,
  input  logic             fec32_datin,
  input  logic             cnt_clr,
  output logic [9:0]       dec_word,
  output logic             dec_valid_p,
  output logic             err_corr_p,
  output logic             err_uncorr_p,
  output logic [4:0]       syndrome,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Low five coefficients of g(D); the D^5 term is the feedback bit itself.
  localparam logic [4:0] G_TAP = 5'b10101;

  logic [3:0]  bcnt;
  logic [4:0]  syn_acc;
  logic [4:0]  syn_next;
  logic [4:0]  syn_snap;
  logic [13:0] rx_sr;
  logic [14:0] blk;
  logic        pending;

  logic [14:0] flip_mask;
  logic [14:0] blk_fix;
  logic        is_corr;
  logic        is_uncorr;
  logic        do_dec;
  logic        inc_corr;
  logic        inc_uncorr;

  // Single-bit error position for each syndrome, i.e. D^k mod g(D).
  function automatic logic [14:0] syn_to_mask(input logic [4:0] s);
    case (s)
      5'b00001: return 15'h0001;
      5'b00010: return 15'h0002;
      5'b00100: return 15'h0004;
      5'b01000: return 15'h0008;
      5'b10000: return 15'h0010;
      5'b10101: return 15'h0020;
      5'b11111: return 15'h0040;
      5'b01011: return 15'h0080;
      5'b10110: return 15'h0100;
      5'b11001: return 15'h0200;
      5'b00111: return 15'h0400;
      5'b01110: return 15'h0800;
      5'b11100: return 15'h1000;
      5'b01101: return 15'h2000;
      5'b11010: return 15'h4000;
      default:  return 15'h0000;
    endcase
  endfunction

  // NOTE: every combinational output gets an unconditional assignment, so no latch is inferred.
  always_comb begin
    syn_next   = {syn_acc[3:0], fec32_datin} ^ (syn_acc[4] ? G_TAP : 5'b00000);
    flip_mask  = syn_to_mask(syn_snap);
    blk_fix    = blk ^ flip_mask;
    is_corr    = |flip_mask;
    is_uncorr  = (syn_snap != 5'b00000) && !is_corr;
    do_dec     = pending && !loadini_p;
    inc_corr   = do_dec && is_corr;
    inc_uncorr = do_dec && is_uncorr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      bcnt         <= '0;
      syn_acc      <= '0;
      syn_snap     <= '0;
      rx_sr        <= '0;
      blk          <= '0;
      pending      <= 1'b0;
      dec_word     <= '0;
      dec_valid_p  <= 1'b0;
      err_corr_p   <= 1'b0;
      err_uncorr_p <= 1'b0;
      syndrome     <= '0;
      corr_cnt     <= '0;
      uncorr_cnt   <= '0;
    end else begin
      dec_valid_p  <= 1'b0;
      err_corr_p   <= 1'b0;
      err_uncorr_p <= 1'b0;

      if (loadini_p) begin
        bcnt    <= '0;
        syn_acc <= '0;
        pending <= 1'b0;
      end else begin
        // Decode works from the snapshot, so the next block may already be shifting in.
        if (pending) begin
          pending      <= 1'b0;
          dec_valid_p  <= 1'b1;
          dec_word     <= blk_fix[14:5];
          syndrome     <= syn_snap;
          err_corr_p   <= is_corr;
          err_uncorr_p <= is_uncorr;
        end
        if (datvalid_p) begin
          rx_sr <= {rx_sr[12:0], fec32_datin};
          if (bcnt == 4'd14) begin
            bcnt     <= '0;
            syn_acc  <= '0;
            blk      <= {rx_sr, fec32_datin};
            syn_snap <= syn_next;
            pending  <= 1'b1;
          end else begin
            bcnt    <= bcnt + 4'd1;
            syn_acc <= syn_next;
          end
        end
      end

      if (cnt_clr) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end else begin
        if (inc_corr && (corr_cnt != {CNT_W{1'b1}}))
          corr_cnt <= corr_cnt + 1'b1;
        if (inc_uncorr && (uncorr_cnt != {CNT_W{1'b1}}))
          uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fec32_dec.sv
// Self-checking bench for fec32_dec: polynomial-arithmetic reference model compared every cycle,
// plus directed literal checks for known codewords, abort handling and counter saturation.
module tb_fec32_dec;

  localparam int CNT_W = 8;

  logic             clk_6M = 1'b0;
  logic             rst, loadini_p, datvalid_p, fec32_datin, cnt_clr;
  logic [9:0]       dec_word;
  logic             dec_valid_p, err_corr_p, err_uncorr_p;
  logic [4:0]       syndrome;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

  fec32_dec #(.CNT_W(CNT_W)) dut (
    .clk_6M       (clk_6M),
    .rst          (rst),
    .loadini_p    (loadini_p),
    .datvalid_p   (datvalid_p),
    .fec32_datin  (fec32_datin),
    .cnt_clr      (cnt_clr),
    .dec_word     (dec_word),
    .dec_valid_p  (dec_valid_p),
    .err_corr_p   (err_corr_p),
    .err_uncorr_p (err_uncorr_p),
    .syndrome     (syndrome),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  always #83 clk_6M = ~clk_6M;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Remainder of a 15-bit polynomial (bit k = D^k) divided by g(D).
  function automatic logic [4:0] polymod(input logic [14:0] p);
    logic [14:0] r;
    r = p;
    for (int b = 14; b >= 5; b--)
      if (r[b]) r = r ^ (15'b110101 << (b - 5));
    return r[4:0];
  endfunction

  function automatic logic [14:0] encode(input logic [9:0] d);
    logic [14:0] m;
    m = {d, 5'b00000};
    return m | {10'b0, polymod(m)};
  endfunction

  // ---------------- reference model, advanced once per clock ----------------
  int          m_nbits;
  logic [14:0] m_acc;
  bit          m_pend;
  logic [14:0] m_blk;
  logic [9:0]  m_word;
  logic [4:0]  m_syn;
  bit          m_valid, m_corr, m_uncorr;
  int          m_ccnt, m_ucnt;

  // Captured DUT results for directed checks.
  int          n_valid = 0;
  logic [9:0]  cap_word;
  logic [4:0]  cap_syn;
  logic        cap_corr, cap_uncorr;
  logic [9:0]  word_q[$];

  task automatic model_reset();
    m_nbits = 0; m_acc = '0; m_pend = 0; m_blk = '0;
    m_word = '0; m_syn = '0; m_valid = 0; m_corr = 0; m_uncorr = 0;
    m_ccnt = 0; m_ucnt = 0;
  endtask

  task automatic model_decode();
    logic [4:0]  s;
    logic [14:0] fixed;
    bit          found;
    s = polymod(m_blk);
    fixed = m_blk;
    found = 0;
    for (int k = 0; k < 15; k++)
      if (!found && s != 0 && polymod(15'(1) << k) == s) begin
        fixed = m_blk ^ (15'(1) << k);
        found = 1;
      end
    m_valid  = 1;
    m_word   = fixed[14:5];
    m_syn    = s;
    m_corr   = found;
    m_uncorr = (s != 0) && !found;
  endtask

  always @(posedge clk_6M) begin
    logic ld, dv, d, clr, r;
    ld = loadini_p; dv = datvalid_p; d = fec32_datin; clr = cnt_clr; r = rst;
    if (r) model_reset();
    else begin
      m_valid = 0; m_corr = 0; m_uncorr = 0;
      if (ld) begin
        m_nbits = 0; m_pend = 0;
      end else begin
        if (m_pend) begin
          model_decode();
          m_pend = 0;
        end
        if (dv) begin
          m_acc = {m_acc[13:0], d};
          m_nbits++;
          if (m_nbits == 15) begin
            m_blk = m_acc; m_pend = 1; m_nbits = 0;
          end
        end
      end
      if (clr) begin
        m_ccnt = 0; m_ucnt = 0;
      end else begin
        if (m_corr && m_ccnt < 255) m_ccnt++;
        if (m_uncorr && m_ucnt < 255) m_ucnt++;
      end
    end
    #1;
    check("dec_valid_p", 32'(dec_valid_p), 32'(m_valid));
    check("err_corr_p", 32'(err_corr_p), 32'(m_corr));
    check("err_uncorr_p", 32'(err_uncorr_p), 32'(m_uncorr));
    check("dec_word", 32'(dec_word), 32'(m_word));
    check("syndrome", 32'(syndrome), 32'(m_syn));
    check("corr_cnt", 32'(corr_cnt), 32'(m_ccnt));
    check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_ucnt));
    if (dec_valid_p) begin
      n_valid++;
      cap_word = dec_word; cap_syn = syndrome;
      cap_corr = err_corr_p; cap_uncorr = err_uncorr_p;
      word_q.push_back(dec_word);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ld, input logic dv, input logic d, input logic clr);
    @(negedge clk_6M);
    loadini_p = ld; datvalid_p = dv; fec32_datin = d; cnt_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic send_bits(input logic [14:0] cw, input int nb, input int gapmax);
    for (int i = 14; i > 14 - nb; i--) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      drive(0, 1, cw[i], 0);
    end
  endtask

  task automatic send_cw(input logic [14:0] cw, input int gapmax);
    send_bits(cw, 15, gapmax);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
  endtask

  function automatic logic [14:0] single_err();
    return 15'(1) << $urandom_range(0, 14);
  endfunction

  logic [9:0]  data_list[20];
  logic [14:0] err_list[20];
  logic [9:0]  seq_a[$];
  int          v0;

  initial begin
    model_reset();
    rst = 1'b1; loadini_p = 0; datvalid_p = 0; fec32_datin = 0; cnt_clr = 0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset dec_word", 32'(dec_word), 32'h0);
    check("reset syndrome", 32'(syndrome), 32'h0);
    check("reset corr_cnt", 32'(corr_cnt), 32'h0);
    check("reset flags", 32'({dec_valid_p, err_corr_p, err_uncorr_p}), 32'h0);

    // All-zero codeword.
    v0 = n_valid;
    send_cw(15'h0000, 0); idle(3);
    check("t1 valid count", 32'(n_valid - v0), 32'd1);
    check("t1 word", 32'(cap_word), 32'h0);
    check("t1 syn", 32'(cap_syn), 32'h0);
    check("t1 flags", 32'({cap_corr, cap_uncorr}), 32'h0);

    // First bit flipped.
    send_cw(15'h4000, 0); idle(3);
    check("t2 syn", 32'(cap_syn), 32'b11010);
    check("t2 corr", 32'(cap_corr), 32'h1);
    check("t2 word", 32'(cap_word), 32'h0);
    check("t2 corr_cnt", 32'(corr_cnt), 32'd1);

    // D^14 + D^13 flipped.
    send_cw(15'h6000, 0); idle(3);
    check("t3 syn", 32'(cap_syn), 32'b10111);
    check("t3 uncorr", 32'(cap_uncorr), 32'h1);
    check("t3 word", 32'(cap_word), 32'h300);
    check("t3 uncorr_cnt", 32'(uncorr_cnt), 32'd1);

    // Last parity bit of encoded 0x3FF flipped.
    send_cw(encode(10'h3FF) ^ 15'h0001, 0); idle(3);
    check("t4 syn", 32'(cap_syn), 32'b00001);
    check("t4 corr", 32'(cap_corr), 32'h1);
    check("t4 word", 32'(cap_word), 32'h3FF);

    // Abort after 7 bits, then a clean block.
    v0 = n_valid;
    send_bits(15'h7FFF, 7, 0);
    drive(1, 1, 1, 0);
    send_cw(encode(10'h2A5), 0); idle(3);
    check("t5 valid count", 32'(n_valid - v0), 32'd1);
    check("t5 word", 32'(cap_word), 32'h2A5);
    check("t5 syn", 32'(cap_syn), 32'h0);

    // loadini_p in the decode cycle drops the block.
    v0 = n_valid;
    send_cw(encode(10'h155) ^ 15'h0100, 0);
    drive(1, 0, 0, 0);
    idle(3);
    check("drop valid count", 32'(n_valid - v0), 32'd0);

    // Back-to-back blocks with no idle between them.
    for (int i = 0; i < 20; i++) begin
      data_list[i] = 10'($urandom);
      err_list[i]  = ($urandom_range(0, 1) != 0) ? single_err() : 15'h0;
    end
    word_q.delete();
    for (int i = 0; i < 20; i++) send_cw(encode(data_list[i]) ^ err_list[i], 0);
    idle(3);
    seq_a = word_q;
    word_q.delete();
    for (int i = 0; i < 20; i++) send_cw(encode(data_list[i]) ^ err_list[i], 3);
    idle(3);
    check("gap seq length", 32'(word_q.size()), 32'(seq_a.size()));
    for (int i = 0; i < 20 && i < seq_a.size() && i < word_q.size(); i++) begin
      check("gap vs b2b word", 32'(word_q[i]), 32'(seq_a[i]));
      check("corrected data", 32'(word_q[i]), 32'(data_list[i]));
    end

    // Counter saturation and clear priority.
    drive(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) send_cw(encode(10'($urandom)) ^ single_err(), 0);
    idle(3);
    check("corr_cnt saturated", 32'(corr_cnt), 32'd255);
    send_cw(encode(10'h0F0) ^ 15'h0400, 0);
    drive(0, 0, 0, 1);
    idle(2);
    check("clr beats increment", 32'(corr_cnt), 32'd0);

    // Randomized traffic with aborts, clears and resets.
    for (int n = 0; n < 250; n++) begin
      logic [14:0] cw;
      int mode;
      cw = encode(10'($urandom));
      mode = $urandom_range(0, 3);
      if (mode == 1) cw ^= single_err();
      else if (mode == 2) cw ^= 15'(1) << $urandom_range(0, 14) | 15'(1) << $urandom_range(0, 14);
      else if (mode == 3) cw ^= 15'($urandom);
      case ($urandom_range(0, 19))
        0: begin send_bits(cw, $urandom_range(1, 14), 2); drive(1, $urandom_range(0, 1), 1, 0); end
        1: begin send_bits(cw, $urandom_range(1, 14), 2); do_reset(); end
        2: begin send_cw(cw, 0); drive(1, 0, 0, 0); end
        3: begin send_cw(cw, 1); rst = 1'b1; idle(1); rst = 1'b0; end
        4: begin send_cw(cw, 2); drive(0, 0, 0, 1); end
        default: send_cw(cw, $urandom_range(0, 2));
      endcase
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
